// File: rtl/paral_serial_tx_pkg.sv
// Shared constants and types for the two-lane parallel-to-serial transmitter.
package paral_serial_tx_pkg;

    localparam int unsigned DATA_SIZE  = 8;
    localparam int unsigned CNT_W      = $clog2(DATA_SIZE);
    localparam int unsigned SYNC_WORDS = 4;
    localparam int unsigned SYNC_W     = $clog2(SYNC_WORDS + 1);
    localparam int unsigned POP_BIT    = DATA_SIZE - 2;

    localparam logic [DATA_SIZE-1:0] IDLE_WORD = 8'hBC;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } tx_state_e;

    // Converts a bit position into a value of the bit-counter width.
    function automatic logic [CNT_W-1:0] cnt_const(input int unsigned v);
        return CNT_W'(v);
    endfunction

endpackage

// File: rtl/paral_serial_tx_if.sv
// FIFO-side bundle of the transmitter: read data, empty flags and pop strobes
// for both lanes.
interface paral_serial_tx_if;
    import paral_serial_tx_pkg::*;

    logic [DATA_SIZE-1:0] data_in0;
    logic [DATA_SIZE-1:0] data_in1;
    logic                 empty0;
    logic                 empty1;
    logic                 pop_0;
    logic                 pop_1;

    // Transmitter side: issues pops, consumes data and empty status.
    modport master (
        output pop_0,
        output pop_1,
        input  data_in0,
        input  data_in1,
        input  empty0,
        input  empty1
    );

    // FIFO side: supplies data and empty status, observes pops.
    modport slave (
        input  pop_0,
        input  pop_1,
        output data_in0,
        output data_in1,
        output empty0,
        output empty1
    );
endinterface

// File: rtl/paral_serial_tx_lane.sv
// One transmit lane: MSB-first shift register, idle/data load mux and the
// registered "popped this word" flag that selects data on the next load.
module tx_lane
    import paral_serial_tx_pkg::*;
(
    input  logic                 clk8f,
    input  logic                 reset,
    input  logic [CNT_W-1:0]     bit_cnt,
    input  logic                 pop_en,
    input  logic                 empty,
    input  logic [DATA_SIZE-1:0] data_in,
    output logic                 out,
    output logic                 pop
);

    localparam logic [CNT_W-1:0] POP_IDX  = cnt_const(POP_BIT);
    localparam logic [CNT_W-1:0] LOAD_IDX = cnt_const(DATA_SIZE - 1);

    logic [DATA_SIZE-1:0] sh_r;
    logic                 popped_r;
    logic                 pop_s;

    // Pop is requested only in the bit POP_IDX slot, so at most once per word;
    // the FIFO answers during the last bit slot, just before the load edge.
    assign pop_s = pop_en && !empty && (bit_cnt == POP_IDX);
    assign pop   = pop_s;
    assign out   = sh_r[DATA_SIZE-1];

    // Remember whether this word's pop slot fetched a word for the next load.
    always_ff @(posedge clk8f or negedge reset) begin
        if (!reset) begin
            popped_r <= 1'b0;
        end else if (bit_cnt == POP_IDX) begin
            popped_r <= pop_s;
        end else begin
            popped_r <= popped_r;
        end
    end

    // Shift register: load FIFO data or the idle word at the word boundary,
    // otherwise shift MSB-first.
    always_ff @(posedge clk8f or negedge reset) begin
        if (!reset) begin
            sh_r <= {DATA_SIZE{1'b0}};
        end else if (bit_cnt == LOAD_IDX) begin
            sh_r <= popped_r ? data_in : IDLE_WORD;
        end else begin
            sh_r <= {sh_r[DATA_SIZE-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/paral_serial_tx.sv
// Two-lane parallel-to-serial transmitter. Sends SYNC_WORDS idle words after
// reset, then each lane streams FIFO words or idles when its FIFO is empty.
module paral_serial_tx
    import paral_serial_tx_pkg::*;
(
    input  logic              clk8f,
    input  logic              reset,
    paral_serial_tx_if.master fifo,
    output logic              out0,
    output logic              out1,
    output logic              active
);

    localparam logic [CNT_W-1:0]  LAST_BIT  = cnt_const(DATA_SIZE - 1);
    localparam logic [SYNC_W-1:0] SYNC_DONE = SYNC_W'(SYNC_WORDS);

    logic [CNT_W-1:0]  bit_cnt_r;
    logic [SYNC_W-1:0] sync_cnt_r;
    logic [SYNC_W-1:0] sync_cnt_nxt_s;
    tx_state_e         state_r;
    tx_state_e         state_nxt_s;
    logic              active_r;
    logic              active_nxt_s;
    logic              load_s;
    logic              pop_en_s;

    assign load_s   = (bit_cnt_r == LAST_BIT);
    // The pop slot of the last forced idle word is already allowed, so the
    // first data word follows the sync sequence without a gap.
    assign pop_en_s = (state_r == ACTIVE) || (sync_cnt_r == SYNC_DONE);
    assign active   = active_r;

    // Shared bit counter keeps both lanes word-aligned; starts at the last
    // bit so the first edge after reset is a load edge.
    always_ff @(posedge clk8f or negedge reset) begin
        if (!reset) begin
            bit_cnt_r <= LAST_BIT;
        end else begin
            bit_cnt_r <= bit_cnt_r + cnt_const(1);
        end
    end

    // FSM state, sync word counter and active flag registers.
    always_ff @(posedge clk8f or negedge reset) begin
        if (!reset) begin
            state_r    <= SYNC;
            sync_cnt_r <= {SYNC_W{1'b0}};
            active_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            sync_cnt_r <= sync_cnt_nxt_s;
            active_r   <= active_nxt_s;
        end
    end

    // Next-state logic: count forced idle loads, go ACTIVE on the load that
    // starts the first word after the sync sequence.
    always_comb begin
        state_nxt_s    = state_r;
        sync_cnt_nxt_s = sync_cnt_r;
        active_nxt_s   = active_r;
        case (state_r)
            SYNC: begin
                if (load_s && (sync_cnt_r == SYNC_DONE)) begin
                    state_nxt_s  = ACTIVE;
                    active_nxt_s = 1'b1;
                end else if (load_s) begin
                    sync_cnt_nxt_s = sync_cnt_r + SYNC_W'(1'b1);
                end else begin
                    sync_cnt_nxt_s = sync_cnt_r;
                end
            end
            ACTIVE: begin
                state_nxt_s  = ACTIVE;
                active_nxt_s = 1'b1;
            end
            default: begin
                state_nxt_s  = SYNC;
                active_nxt_s = 1'b0;
            end
        endcase
    end

    tx_lane u_lane0 (
        .clk8f   (clk8f),
        .reset   (reset),
        .bit_cnt (bit_cnt_r),
        .pop_en  (pop_en_s),
        .empty   (fifo.empty0),
        .data_in (fifo.data_in0),
        .out     (out0),
        .pop     (fifo.pop_0)
    );

    tx_lane u_lane1 (
        .clk8f   (clk8f),
        .reset   (reset),
        .bit_cnt (bit_cnt_r),
        .pop_en  (pop_en_s),
        .empty   (fifo.empty1),
        .data_in (fifo.data_in1),
        .out     (out1),
        .pop     (fifo.pop_1)
    );

endmodule

// File: tb/tb_paral_serial_tx.sv
// Scoreboard bench for paral_serial_tx: stimulus pushes the expected
// {out0,out1,pop_0,pop_1,active} of every cycle; a monitor compares at negedge.
module tb_paral_serial_tx;
    import paral_serial_tx_pkg::*;

    typedef struct {
        logic [4:0] v;
        int         tag;
    } exp_t;

    logic clk8f = 1'b0;
    logic reset;
    logic out0;
    logic out1;
    logic active;

    exp_t       exp_q[$];
    logic [7:0] fifo0[$];
    logic [7:0] fifo1[$];
    logic       gap0;
    int         errors = 0;
    int         checks = 0;
    int         tag_cnt = 0;

    paral_serial_tx_if fifo_if ();

    paral_serial_tx dut (
        .clk8f  (clk8f),
        .reset  (reset),
        .fifo   (fifo_if.master),
        .out0   (out0),
        .out1   (out1),
        .active (active)
    );

    always #5 clk8f = ~clk8f;

    // Monitor: one expected entry per cycle, compared mid-cycle.
    always @(negedge clk8f) begin
        exp_t       e;
        logic [4:0] got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {out0, out1, fifo_if.pop_0, fifo_if.pop_1, active};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL cycle_check slot=%0d got{out0,out1,pop0,pop1,active}=%b required=%b",
                         e.tag, got, e.v);
            end
        end
    end

    task automatic upd_empty();
        fifo_if.empty0 = (fifo0.size() == 0) || gap0;
        fifo_if.empty1 = (fifo1.size() == 0);
    endtask

    // One clock: note pops mid-cycle, then behave like a FIFO after the edge.
    task automatic tick();
        logic p0;
        logic p1;
        @(negedge clk8f);
        p0 = fifo_if.pop_0;
        p1 = fifo_if.pop_1;
        @(posedge clk8f);
        #1;
        if (p0 && fifo0.size() > 0) fifo_if.data_in0 = fifo0.pop_front();
        if (p1 && fifo1.size() > 0) fifo_if.data_in1 = fifo1.pop_front();
        upd_empty();
    endtask

    task automatic expect_cycle(input logic [4:0] v);
        exp_t e;
        e.v   = v;
        e.tag = tag_cnt;
        tag_cnt++;
        exp_q.push_back(e);
    endtask

    // Expect one word per lane (MSB first); p0/p1 mark a pop in the bit-6 slot.
    task automatic run_word(input logic [7:0] w0, input logic [7:0] w1,
                            input logic p0, input logic p1, input logic a,
                            input logic late_en = 1'b0, input logic [7:0] late_d = 8'h00,
                            input int nbits = 8);
        for (int b = 0; b < nbits; b++) begin
            expect_cycle({w0[7-b], w1[7-b], p0 && (b == 6), p1 && (b == 6), a});
            if (late_en && b == 7) begin
                fifo0.push_back(late_d);
                upd_empty();
            end
            tick();
        end
    endtask

    // Hold reset low n cycles, release, and expect all-zero outputs throughout.
    task automatic do_reset(input int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            expect_cycle(5'b00000);
            tick();
        end
        reset = 1'b1;
        expect_cycle(5'b00000);
        tick();
    endtask

    initial begin
        reset            = 1'b0;
        gap0             = 1'b0;
        fifo_if.data_in0 = 8'h00;
        fifo_if.data_in1 = 8'h00;
        upd_empty();

        // Reset and sync with both FIFOs empty: four forced idles, active at 32.
        do_reset(6);
        for (int k = 0; k < 4; k++) run_word(8'hBC, 8'hBC, 1'b0, 1'b0, 1'b0);
        run_word(8'hBC, 8'hBC, 1'b0, 1'b0, 1'b1);

        // First data and back-to-back stream on lane 0; FIFO full during sync.
        fifo0 = '{8'hFF, 8'hDD, 8'hEE, 8'hCC, 8'h99, 8'hAA, 8'h88};
        upd_empty();
        do_reset(6);
        for (int k = 0; k < 3; k++) run_word(8'hBC, 8'hBC, 1'b0, 1'b0, 1'b0);
        run_word(8'hBC, 8'hBC, 1'b1, 1'b0, 1'b0);
        run_word(8'hFF, 8'hBC, 1'b1, 1'b0, 1'b1);
        run_word(8'hDD, 8'hBC, 1'b1, 1'b0, 1'b1);
        run_word(8'hEE, 8'hBC, 1'b1, 1'b0, 1'b1);
        run_word(8'hCC, 8'hBC, 1'b1, 1'b0, 1'b1);
        run_word(8'h99, 8'hBC, 1'b1, 1'b0, 1'b1);
        run_word(8'hAA, 8'hBC, 1'b1, 1'b0, 1'b1);
        run_word(8'h88, 8'hBC, 1'b0, 1'b0, 1'b1);
        // Data arriving in the bit-7 slot waits for the next word's pop slot.
        run_word(8'hBC, 8'hBC, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55);
        fifo0.push_back(8'h66);
        fifo0.push_back(8'h77);
        upd_empty();
        run_word(8'hBC, 8'hBC, 1'b1, 1'b0, 1'b1);
        fifo1.push_back(8'h3C);
        upd_empty();
        run_word(8'h55, 8'hBC, 1'b1, 1'b1, 1'b1);
        // One-word gap on lane 0: exactly one idle inserted.
        gap0 = 1'b1;
        upd_empty();
        run_word(8'h66, 8'h3C, 1'b0, 1'b0, 1'b1);
        gap0 = 1'b0;
        upd_empty();
        run_word(8'hBC, 8'hBC, 1'b1, 1'b0, 1'b1);
        fifo0.push_back(8'hA5);
        upd_empty();
        run_word(8'h77, 8'hBC, 1'b1, 1'b0, 1'b1);

        // Mid-word reset at bit 3 of a data word, with both FIFOs loaded.
        run_word(8'hA5, 8'hBC, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3);
        fifo0.push_back(8'h42);
        fifo1.push_back(8'h24);
        upd_empty();
        do_reset(6);
        for (int k = 0; k < 3; k++) run_word(8'hBC, 8'hBC, 1'b0, 1'b0, 1'b0);
        run_word(8'hBC, 8'hBC, 1'b1, 1'b1, 1'b0);
        run_word(8'h42, 8'h24, 1'b0, 1'b0, 1'b1);
        run_word(8'hBC, 8'hBC, 1'b0, 1'b0, 1'b1);

        // Every expected slot must have been consumed by the monitor.
        repeat (3) @(posedge clk8f);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/paral_serial_tx.md
Name: paral_serial_tx

Overview:
- Two-lane parallel-to-serial transmitter. It is the transmit end of the lane protocol whose receiver deserialises in0/in1, detects 0xBC idle words and goes active after 4 of them.
- Each lane pops 8-bit words from its own upstream FIFO and shifts them out MSB-first, one bit per clk8f cycle.
- After reset, both lanes send SYNC_WORDS idle words. After that, a lane sends 0xBC whenever its FIFO is empty.

Parameters:
- DATA_SIZE, 8, word width. Must be a power of 2.
- IDLE_WORD, 8'hBC, idle/sync word.
- SYNC_WORDS, 4, number of forced idle words sent after reset before popping is allowed.

Ports:
- clk8f  in  1  the block's only clock; bit rate.
- reset  in  1  asynchronous, active-low reset.
- data_in0  in  DATA_SIZE  lane-0 FIFO read data; valid the cycle after pop_0.
- data_in1  in  DATA_SIZE  lane-1 FIFO read data; valid the cycle after pop_1.
- empty0  in  1  lane-0 FIFO empty.
- empty1  in  1  lane-1 FIFO empty.
- pop_0  out  1  lane-0 FIFO read strobe, one cycle wide.
- pop_1  out  1  lane-1 FIFO read strobe, one cycle wide.
- out0  out  1  lane-0 serial bit.
- out1  out  1  lane-1 serial bit.
- active  out  1  high once sync is complete; data words may then be sent.

Behaviour:
- Interface: one clock, clk8f. reset is asynchronous and active-low.
- While reset=0: out0=out1=0, pop_0=pop_1=0, active=0, bit_cnt=7, shift registers=0, sync_cnt=0, state=SYNC.
- Assertion at any time, including mid-word, takes effect immediately. The partial word is abandoned and no pop is issued.
- Shared bit_cnt, width log2(DATA_SIZE):
  - increments every clk8f and wraps from 7 to 0;
  - both lanes are always word-aligned.
- Per-lane shift register sh, with out = sh[DATA_SIZE-1], registered:
  - on the edge where bit_cnt goes 7->0, sh loads a new word;
  - on every other edge, sh <= sh << 1.
- Cycle numbering: cycle 0 is the first cycle after the first rising edge following reset release. Bit 0 of word 1 appears in cycle 0.
- Load mux, per lane: sh <= data_in if that lane popped in the bit_cnt==6 cycle of the current word, else IDLE_WORD. The pop flag is registered internally.
- Pop rule, per lane: pop high for exactly the cycle where bit_cnt==6, iff pop_en && !empty.
  - The FIFO samples pop at the end of that cycle and presents data during the bit_cnt==7 cycle.
  - The transmitter samples the data at the end of the bit_cnt==7 cycle.
  - One pop at most per word per lane.
  - Lanes pop independently, so one lane may send data while the other sends idle.
- State machine (SYNC, ACTIVE):
  - SYNC: every load is IDLE_WORD. sync_cnt increments on each load.
  - pop_en is high in state ACTIVE, or in SYNC once sync_cnt==SYNC_WORDS, which covers bit 6 of the last forced word.
  - On the load edge that starts word SYNC_WORDS+1, the state goes to ACTIVE and active goes to 1. This is at cycle 32 for the defaults.
  - ACTIVE persists until reset.
- empty deasserting in the cycle after bit_cnt==6 has no effect on the current word; it is honoured in the next word's bit 6.
- data_in is ignored in every cycle except the one sampled after a pop.
- No bit inversion and no scrambling.

Decomposition:
- Shared package holds:
  - IDLE_WORD = 8'hBC;
  - SYNC_WORDS = 4;
  - state encoding SYNC=1'b0, ACTIVE=1'b1;
  - POP_BIT = DATA_SIZE-2.
- Sub-module tx_lane, instantiated twice: shift register, load mux, pop flag. Its inputs are bit_cnt, pop_en, empty and data_in; its outputs are out and pop.
- Top level owns bit_cnt, sync_cnt and the FSM.

Test Plan:
- Reset and sync: reset low for 6 cycles, then high, empty0=empty1=1.
  - out0/out1 = 10111100 repeated from cycle 0.
  - active rises at cycle 32.
  - pop_0 and pop_1 never assert.
- First data: empty0=0, data_in0=8'hFF.
  - pop_0 high in cycle 30 only.
  - out0=1 for cycles 32-39.
  - out1 still sends BC.
- Stream: FIFO0 holds DD, EE, CC, 99, AA, 88 back-to-back.
  - pop_0 in cycles 30, 38, 46, ...
  - out0 bit sequence 11011101 11101110 11001100 10011001 10101010 10001000.
  - A BC word follows once empty0=1.
- Gap: empty0 goes 1 for one word mid-stream.
  - No pop in that word's bit 6.
  - Exactly one 10111100 is inserted, then data resumes.
- Mid-word reset: reset=0 at bit_cnt==3 of a data word.
  - out0=out1=0, pop=0, active=0 immediately.
  - After release, 4 BC words are sent again before any pop.
- Lane independence: empty0=0 with data 8'hAA, empty1=1.
  - Only pop_0 pulses.
  - out0=10101010 while out1=10111100 in the same cycles.
